drive_mode_ctrl: RTL and testbench
==================================

Name: drive_mode_ctrl

Overview:
- Parametrised top-level mode controller for the tracking robot: selects IDLE / CAM / IR mode from IR remote codes and runs the camera-tracking sub-FSM (SEARCH / FOLLOW / PAUSE).
- Issues a registered drive command to the motor block and a stretched sub-reset pulse to downstream blocks.
- Adds a valid-qualified IR input, loss-of-target hysteresis, search timeout, manual IR driving with speed stepping, and N speed levels.

Parameters:
- NUM_SPEEDS, 3, forward speed levels (>=1)
- CODE_CAM, 8'h0F, IR code selecting CAM mode
- CODE_IR, 8'h13, IR code selecting IR mode
- CODE_IDLE, 8'h10, IR code selecting IDLE
- CODE_FWD / CODE_LEFT / CODE_RIGHT / CODE_STOP, 8'h18 / 8'h08 / 8'h5A / 8'h1C, manual drive codes (IR mode only)
- LOST_HOLD, 1_000_000, consecutive no-detect cycles before FOLLOW->SEARCH
- SEARCH_TIMEOUT, 250_000_000, cycles in SEARCH without detection before PAUSE
- RESET_PULSE, 4, sub_reset width in cycles (>=1)

Ports:
- clk_50 in 1: system clock
- reset in 1: asynchronous, active-high reset
- ir_valid in 1: one-cycle strobe qualifying ir_code
- ir_code in 8: decoded remote button
- orange_detected in 1: camera target present
- cam_direction in 3: 3'b001 left, 3'b010 right, 3'b011 centre, other = invalid
- speed in SPD_W = max(1,$clog2(NUM_SPEEDS)): camera-requested speed level
- mode out 2: IDLE=0, CAM=1, IR=2
- cam_state out 2: SEARCH=0, FOLLOW=1, PAUSE=3
- drive_cmd out DRV_W = $clog2(NUM_SPEEDS+3): STOP=0, LEFT=1, RIGHT=2, SPEED_k=3+k
- sub_reset out 1: stretched reset to downstream blocks
- hex7, hex6 out 7 each: active-low mode letters (IDLE "Id", CAM "CA", IR "Ir")

Behaviour:
- Reset (async): mode=IDLE, cam_state=PAUSE, drive_cmd=STOP, counters 0, manual cmd STOP, sub_reset=1; after release sub_reset stays high RESET_PULSE further cycles.
- ir_code ignored unless ir_valid=1; unknown codes ignored.
- Mode FSM: CODE_CAM->CAM, CODE_IR->IR, CODE_IDLE->IDLE, from any mode; code of current mode = no mode change.
- Cam FSM, evaluated against next mode in the same cycle:
  - next mode != CAM -> PAUSE.
  - Entering CAM -> SEARCH.
  - CODE_CAM while already in CAM and PAUSE -> SEARCH (re-arm after timeout).
  - SEARCH: orange_detected -> FOLLOW. Search timer reaching SEARCH_TIMEOUT-1 without detection -> PAUSE. Timer clears on entering SEARCH.
  - FOLLOW: lost counter counts consecutive cycles with orange_detected=0 and clears on detect. Reaching LOST_HOLD -> SEARCH.
- Mode-change code wins over a simultaneous detection event.
- drive_cmd registered from next-state values (visible the edge after the causing input):
  - CAM/SEARCH -> RIGHT; CAM/PAUSE -> STOP; IDLE -> STOP.
  - CAM/FOLLOW: dir 001 -> LEFT; 010 -> RIGHT; 011 -> SPEED_min(speed, NUM_SPEEDS-1); invalid dir -> STOP.
  - IR: manual cmd. Entering IR sets STOP.
    - CODE_LEFT / RIGHT / STOP set the corresponding cmd.
    - CODE_FWD from non-SPEED -> SPEED_0; from SPEED_k -> SPEED_min(k+1, NUM_SPEEDS-1) (saturating).
- sub_reset: any change of mode or cam_state loads the pulse counter with RESET_PULSE. sub_reset=1 while counter != 0, starting the cycle after the transition edge. A retrigger reloads the counter, giving no gap.
- Reset asserted mid-operation overrides everything immediately; counters restart from 0.

Decomposition:
- Package drive_mode_pkg: mode_t, cam_state_t, drive cmd encodings, cam_direction constants, hex glyph constants.
- One sub-module, pulse_stretcher (RESET_PULSE, trigger in, pulse out); all else in the top.

Test Plan (NUM_SPEEDS=3, LOST_HOLD=4, SEARCH_TIMEOUT=16, RESET_PULSE=3):
- Release reset, no input -> sub_reset high 3 cycles then low; mode=0, cam_state=3, drive_cmd=0, hex7=7'b1111001.
- ir_code=8'h0F with ir_valid=0, then ir_valid=1 -> no change, then mode=1, cam_state=0, drive_cmd=2 next edge, sub_reset 3 cycles.
- CAM/SEARCH, orange=1, dir=011, speed=3 -> FOLLOW, drive_cmd=5 (clamped). Drop orange 3 cycles then re-detect -> stays FOLLOW. Drop 4 cycles -> SEARCH, drive_cmd=2.
- SEARCH with orange=0 for 16 cycles -> PAUSE, drive_cmd=0. Then CODE_CAM -> SEARCH.
- Enter IR, CODE_FWD x4 -> drive_cmd 3,4,5,5. CODE_LEFT -> 1. CODE_IDLE -> mode=0, drive_cmd=0.
- Same cycle: orange 0->1 in SEARCH and ir_code=8'h10 valid -> mode=IDLE, cam_state=PAUSE. Reset asserted mid-FOLLOW -> outputs at reset values immediately.

Source files
------------

// File: rtl/drive_mode_ctrl_pkg.sv
// Shared encodings for the tracking-robot mode controller: mode and camera
// sub-state enums, drive command codes, camera direction codes and the
// active-low seven-segment glyphs (bit order gfedcba) used for mode letters.
package drive_mode_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_CAM  = 2'd1,
    MODE_IR   = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    CAM_SEARCH = 2'd0,
    CAM_FOLLOW = 2'd1,
    CAM_PAUSE  = 2'd3
  } cam_state_t;

  // Drive command codes; forward speed level k is DRV_SPEED0 + k.
  localparam int unsigned DRV_STOP   = 0;
  localparam int unsigned DRV_LEFT   = 1;
  localparam int unsigned DRV_RIGHT  = 2;
  localparam int unsigned DRV_SPEED0 = 3;

  localparam logic [2:0] DIR_LEFT   = 3'b001;
  localparam logic [2:0] DIR_RIGHT  = 3'b010;
  localparam logic [2:0] DIR_CENTRE = 3'b011;

  localparam logic [6:0] GLYPH_I = 7'b1111001;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_R = 7'b0101111;

  // Saturate a requested speed level to the highest level that exists.
  function automatic int unsigned clamp_speed(input int unsigned k, input int unsigned n);
    return (k >= n) ? (n - 1) : k;
  endfunction

endpackage

// File: rtl/drive_mode_ctrl_pulse_stretcher.sv
// Stretches a one-cycle trigger into a pulse RESET_PULSE cycles wide.
// The counter comes out of reset loaded, so the output is high throughout
// reset and for RESET_PULSE cycles after release. A retrigger reloads the
// counter, so back-to-back triggers produce one continuous pulse.
module pulse_stretcher #(
  parameter  int unsigned RESET_PULSE = 4,
  localparam int unsigned CNT_W       = $clog2(RESET_PULSE + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic trig_i,
  output logic pulse_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Reload on trigger, otherwise count down to zero and hold.
  always_comb begin
    cnt_d = cnt_q;
    if (trig_i) begin
      cnt_d = CNT_W'(RESET_PULSE);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Pulse counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= CNT_W'(RESET_PULSE);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pulse_o = (cnt_q != '0);

endmodule

// File: rtl/drive_mode_ctrl.sv
// Top-level mode controller for the tracking robot. Selects IDLE / CAM / IR
// from IR remote codes, runs the camera tracking sub-FSM and issues a
// registered drive command plus a stretched sub-reset on every state change.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// MODE_IDLE  | robot stopped, waiting for a mode code
// MODE_CAM   | camera tracking, sub-state below applies
// MODE_IR    | manual driving from remote codes
// CAM_SEARCH | spin right looking for the target, bounded by search timer
// CAM_FOLLOW | steer toward target; LOST_HOLD misses fall back to SEARCH
// CAM_PAUSE  | stopped; outside CAM, or search timed out (CODE_CAM re-arms)
module drive_mode_ctrl
  import drive_mode_pkg::*;
#(
  parameter  int unsigned NUM_SPEEDS     = 3,
  parameter  logic [7:0]  CODE_CAM       = 8'h0F,
  parameter  logic [7:0]  CODE_IR        = 8'h13,
  parameter  logic [7:0]  CODE_IDLE      = 8'h10,
  parameter  logic [7:0]  CODE_FWD       = 8'h18,
  parameter  logic [7:0]  CODE_LEFT      = 8'h08,
  parameter  logic [7:0]  CODE_RIGHT     = 8'h5A,
  parameter  logic [7:0]  CODE_STOP      = 8'h1C,
  parameter  int unsigned LOST_HOLD      = 1_000_000,
  parameter  int unsigned SEARCH_TIMEOUT = 250_000_000,
  parameter  int unsigned RESET_PULSE    = 4,
  localparam int unsigned SPD_W          = (NUM_SPEEDS > 1) ? $clog2(NUM_SPEEDS) : 1,
  localparam int unsigned DRV_W          = $clog2(NUM_SPEEDS + 3)
) (
  input  logic             clk_50,
  input  logic             reset,
  input  logic             ir_valid,
  input  logic [7:0]       ir_code,
  input  logic             orange_detected,
  input  logic [2:0]       cam_direction,
  input  logic [SPD_W-1:0] speed,
  output logic [1:0]       mode,
  output logic [1:0]       cam_state,
  output logic [DRV_W-1:0] drive_cmd,
  output logic             sub_reset,
  output logic [6:0]       hex7,
  output logic [6:0]       hex6
);

  localparam int unsigned LOST_W = $clog2(LOST_HOLD + 1);
  localparam int unsigned TMR_W  = $clog2(SEARCH_TIMEOUT + 1);

  localparam logic [DRV_W-1:0]  CMD_STOP    = DRV_W'(DRV_STOP);
  localparam logic [DRV_W-1:0]  CMD_LEFT    = DRV_W'(DRV_LEFT);
  localparam logic [DRV_W-1:0]  CMD_RIGHT   = DRV_W'(DRV_RIGHT);
  localparam logic [DRV_W-1:0]  CMD_SPD0    = DRV_W'(DRV_SPEED0);
  localparam logic [DRV_W-1:0]  CMD_SPD_MAX = DRV_W'(DRV_SPEED0 + NUM_SPEEDS - 1);
  localparam logic [LOST_W-1:0] LOST_LAST   = LOST_W'(LOST_HOLD - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST    = TMR_W'(SEARCH_TIMEOUT - 1);

  mode_t             mode_q, mode_d;
  cam_state_t        cam_q, cam_d;
  logic [LOST_W-1:0] lost_q, lost_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [DRV_W-1:0]  man_q, man_d;
  logic [DRV_W-1:0]  drv_q, drv_d;
  logic [6:0]        hex7_q, hex7_d, hex6_q, hex6_d;
  logic              hit_cam, hit_ir, hit_idle;
  logic              state_change;

  assign hit_cam  = ir_valid && (ir_code == CODE_CAM);
  assign hit_ir   = ir_valid && (ir_code == CODE_IR);
  assign hit_idle = ir_valid && (ir_code == CODE_IDLE);

  // Mode selection from qualified remote codes; anything else keeps the mode.
  always_comb begin
    mode_d = mode_q;
    if (hit_cam) begin
      mode_d = MODE_CAM;
    end else if (hit_ir) begin
      mode_d = MODE_IR;
    end else if (hit_idle) begin
      mode_d = MODE_IDLE;
    end
  end

  // Camera sub-state, judged against the mode we are moving into so that a
  // mode-change code always beats a same-cycle detection event.
  always_comb begin
    cam_d = cam_q;
    if (mode_d != MODE_CAM) begin
      cam_d = CAM_PAUSE;
    end else if (mode_q != MODE_CAM) begin
      cam_d = CAM_SEARCH;
    end else if (hit_cam && (cam_q == CAM_PAUSE)) begin
      cam_d = CAM_SEARCH;
    end else begin
      case (cam_q)
        CAM_SEARCH: begin
          if (orange_detected) begin
            cam_d = CAM_FOLLOW;
          end else if (tmr_q == TMR_LAST) begin
            cam_d = CAM_PAUSE;
          end
        end
        CAM_FOLLOW: begin
          if (!orange_detected && (lost_q == LOST_LAST)) begin
            cam_d = CAM_SEARCH;
          end
        end
        default: cam_d = cam_q;
      endcase
    end
  end

  // Search timer and lost counter only advance while staying in their state,
  // which also clears them on every entry.
  always_comb begin
    tmr_d  = ((cam_q == CAM_SEARCH) && (cam_d == CAM_SEARCH)) ? tmr_q + 1'b1 : '0;
    lost_d = ((cam_q == CAM_FOLLOW) && (cam_d == CAM_FOLLOW) && !orange_detected)
             ? lost_q + 1'b1 : '0;
  end

  // Manual command in IR mode; forward steps up through the speed levels and
  // saturates at the top one.
  always_comb begin
    man_d = man_q;
    if ((mode_d != MODE_IR) || (mode_q != MODE_IR)) begin
      man_d = CMD_STOP;
    end else if (ir_valid) begin
      if (ir_code == CODE_LEFT) begin
        man_d = CMD_LEFT;
      end else if (ir_code == CODE_RIGHT) begin
        man_d = CMD_RIGHT;
      end else if (ir_code == CODE_STOP) begin
        man_d = CMD_STOP;
      end else if (ir_code == CODE_FWD) begin
        if (man_q < CMD_SPD0) begin
          man_d = CMD_SPD0;
        end else if (man_q >= CMD_SPD_MAX) begin
          man_d = CMD_SPD_MAX;
        end else begin
          man_d = man_q + 1'b1;
        end
      end
    end
  end

  // Drive command from next-state values so it lands with the state change.
  always_comb begin
    drv_d = CMD_STOP;
    case (mode_d)
      MODE_IR: drv_d = man_d;
      MODE_CAM: begin
        case (cam_d)
          CAM_SEARCH: drv_d = CMD_RIGHT;
          CAM_FOLLOW: begin
            case (cam_direction)
              DIR_LEFT:   drv_d = CMD_LEFT;
              DIR_RIGHT:  drv_d = CMD_RIGHT;
              DIR_CENTRE: drv_d = DRV_W'(DRV_SPEED0 + clamp_speed(32'(speed), NUM_SPEEDS));
              default:    drv_d = CMD_STOP;
            endcase
          end
          default: drv_d = CMD_STOP;
        endcase
      end
      default: drv_d = CMD_STOP;
    endcase
  end

  // Mode letters for the two leftmost displays.
  always_comb begin
    hex7_d = GLYPH_I;
    hex6_d = GLYPH_D;
    case (mode_d)
      MODE_CAM: begin
        hex7_d = GLYPH_C;
        hex6_d = GLYPH_A;
      end
      MODE_IR: begin
        hex7_d = GLYPH_I;
        hex6_d = GLYPH_R;
      end
      default: begin
        hex7_d = GLYPH_I;
        hex6_d = GLYPH_D;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      mode_q <= MODE_IDLE;
      cam_q  <= CAM_PAUSE;
      lost_q <= '0;
      tmr_q  <= '0;
      man_q  <= CMD_STOP;
      drv_q  <= CMD_STOP;
      hex7_q <= GLYPH_I;
      hex6_q <= GLYPH_D;
    end else begin
      mode_q <= mode_d;
      cam_q  <= cam_d;
      lost_q <= lost_d;
      tmr_q  <= tmr_d;
      man_q  <= man_d;
      drv_q  <= drv_d;
      hex7_q <= hex7_d;
      hex6_q <= hex6_d;
    end
  end

  assign state_change = (mode_d != mode_q) || (cam_d != cam_q);

  pulse_stretcher #(
    .RESET_PULSE(RESET_PULSE)
  ) u_sub_reset (
    .clk_i  (clk_50),
    .rst_i  (reset),
    .trig_i (state_change),
    .pulse_o(sub_reset)
  );

  assign mode      = mode_q;
  assign cam_state = cam_q;
  assign drive_cmd = drv_q;
  assign hex7      = hex7_q;
  assign hex6      = hex6_q;

endmodule

// File: tb/tb_drive_mode_ctrl.sv
// Directed bench for drive_mode_ctrl with a small expectation queue: each step
// drives inputs, queues the outputs expected after the next edge, then pops
// and compares once that edge has passed.
module tb_drive_mode_ctrl;

  logic       clk_50 = 1'b0;
  logic       reset;
  logic       ir_valid;
  logic [7:0] ir_code;
  logic       orange_detected;
  logic [2:0] cam_direction;
  logic [1:0] speed;
  logic [1:0] mode;
  logic [1:0] cam_state;
  logic [2:0] drive_cmd;
  logic       sub_reset;
  logic [6:0] hex7;
  logic [6:0] hex6;

  typedef struct packed {
    logic [1:0] mode;
    logic [1:0] cam;
    logic [2:0] drv;
    logic       sub;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   n_step  = 0;

  drive_mode_ctrl #(
    .NUM_SPEEDS    (3),
    .LOST_HOLD     (4),
    .SEARCH_TIMEOUT(16),
    .RESET_PULSE   (3)
  ) dut (
    .clk_50         (clk_50),
    .reset          (reset),
    .ir_valid       (ir_valid),
    .ir_code        (ir_code),
    .orange_detected(orange_detected),
    .cam_direction  (cam_direction),
    .speed          (speed),
    .mode           (mode),
    .cam_state      (cam_state),
    .drive_cmd      (drive_cmd),
    .sub_reset      (sub_reset),
    .hex7           (hex7),
    .hex6           (hex6)
  );

  always #5 clk_50 = ~clk_50;

  function automatic logic [6:0] glyph7(input logic [1:0] m);
    return (m == 2'd1) ? 7'b1000110 : 7'b1111001;
  endfunction

  function automatic logic [6:0] glyph6(input logic [1:0] m);
    case (m)
      2'd1:    return 7'b0001000;
      2'd2:    return 7'b0101111;
      default: return 7'b0100001;
    endcase
  endfunction

  function automatic exp_t mk(input logic [1:0] m, input logic [1:0] c,
                              input logic [2:0] d, input logic s);
    exp_t e;
    e.mode = m;
    e.cam  = c;
    e.drv  = d;
    e.sub  = s;
    return e;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  task automatic check_out();
    exp_t e;
    n_step++;
    if (sb.size() == 0) begin
      n_total++;
      $error("FAIL s%0d.queue observed=empty expected=entry", n_step);
    end else begin
      e = sb.pop_front();
      cmp($sformatf("s%0d.mode", n_step), 32'(mode), 32'(e.mode));
      cmp($sformatf("s%0d.cam_state", n_step), 32'(cam_state), 32'(e.cam));
      cmp($sformatf("s%0d.drive_cmd", n_step), 32'(drive_cmd), 32'(e.drv));
      cmp($sformatf("s%0d.sub_reset", n_step), 32'(sub_reset), 32'(e.sub));
      cmp($sformatf("s%0d.hex7", n_step), 32'(hex7), 32'(glyph7(e.mode)));
      cmp($sformatf("s%0d.hex6", n_step), 32'(hex6), 32'(glyph6(e.mode)));
    end
  endtask

  task automatic step(input logic v, input logic [7:0] code, input logic o,
                      input logic [2:0] dir, input logic [1:0] spd,
                      input logic [1:0] em, input logic [1:0] ec,
                      input logic [2:0] ed, input logic es);
    ir_valid        = v;
    ir_code         = code;
    orange_detected = o;
    cam_direction   = dir;
    speed           = spd;
    sb.push_back(mk(em, ec, ed, es));
    @(posedge clk_50);
    #1;
    check_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    ir_valid        = 1'b0;
    ir_code         = 8'h00;
    orange_detected = 1'b0;
    cam_direction   = 3'b000;
    speed           = 2'd0;
    repeat (2) @(posedge clk_50);
    #1;
    sb.push_back(mk(2'd0, 2'd3, 3'd0, 1'b1));
    check_out();
    reset = 1'b0;
    sb.push_back(mk(2'd0, 2'd3, 3'd0, 1'b1));
    #1;
    check_out();

    // sub_reset stays high three more edges after release
    step(0, 8'h00, 0, 3'b000, 2'd0, 2'd0, 2'd3, 3'd0, 1'b1);
    step(0, 8'h00, 0, 3'b000, 2'd0, 2'd0, 2'd3, 3'd0, 1'b1);
    step(0, 8'h00, 0, 3'b000, 2'd0, 2'd0, 2'd3, 3'd0, 1'b0);

    // unqualified code ignored, then qualified CAM code
    step(0, 8'h0F, 0, 3'b000, 2'd0, 2'd0, 2'd3, 3'd0, 1'b0);
    step(1, 8'h0F, 0, 3'b000, 2'd0, 2'd1, 2'd0, 3'd2, 1'b1);
    step(0, 8'h00, 0, 3'b000, 2'd0, 2'd1, 2'd0, 3'd2, 1'b1);
    step(0, 8'h00, 0, 3'b000, 2'd0, 2'd1, 2'd0, 3'd2, 1'b1);
    step(0, 8'h00, 0, 3'b000, 2'd0, 2'd1, 2'd0, 3'd2, 1'b0);

    // detect centre at speed 3 -> clamped to SPEED_2
    step(0, 8'h00, 1, 3'b011, 2'd3, 2'd1, 2'd1, 3'd5, 1'b1);
    step(0, 8'h00, 0, 3'b011, 2'd3, 2'd1, 2'd1, 3'd5, 1'b1);
    step(0, 8'h00, 0, 3'b011, 2'd3, 2'd1, 2'd1, 3'd5, 1'b1);
    step(0, 8'h00, 0, 3'b011, 2'd3, 2'd1, 2'd1, 3'd5, 1'b0);
    step(0, 8'h00, 1, 3'b011, 2'd3, 2'd1, 2'd1, 3'd5, 1'b0);
    step(0, 8'h00, 0, 3'b011, 2'd3, 2'd1, 2'd1, 3'd5, 1'b0);
    step(0, 8'h00, 0, 3'b011, 2'd3, 2'd1, 2'd1, 3'd5, 1'b0);
    step(0, 8'h00, 0, 3'b011, 2'd3, 2'd1, 2'd1, 3'd5, 1'b0);
    step(0, 8'h00, 0, 3'b011, 2'd3, 2'd1, 2'd0, 3'd2, 1'b1);

    // search timeout: 15 more cycles stay, the 16th pauses
    for (int i = 0; i < 15; i++) begin
      step(0, 8'h00, 0, 3'b011, 2'd3, 2'd1, 2'd0, 3'd2, (i < 2) ? 1'b1 : 1'b0);
    end
    step(0, 8'h00, 0, 3'b011, 2'd3, 2'd1, 2'd3, 3'd0, 1'b1);
    step(1, 8'h0F, 0, 3'b011, 2'd3, 2'd1, 2'd0, 3'd2, 1'b1);

    // IR mode manual driving
    step(1, 8'h13, 0, 3'b000, 2'd0, 2'd2, 2'd3, 3'd0, 1'b1);
    step(1, 8'h18, 0, 3'b000, 2'd0, 2'd2, 2'd3, 3'd3, 1'b1);
    step(1, 8'h18, 0, 3'b000, 2'd0, 2'd2, 2'd3, 3'd4, 1'b1);
    step(1, 8'h18, 0, 3'b000, 2'd0, 2'd2, 2'd3, 3'd5, 1'b0);
    step(1, 8'h18, 0, 3'b000, 2'd0, 2'd2, 2'd3, 3'd5, 1'b0);
    step(1, 8'h55, 0, 3'b000, 2'd0, 2'd2, 2'd3, 3'd5, 1'b0);
    step(1, 8'h08, 0, 3'b000, 2'd0, 2'd2, 2'd3, 3'd1, 1'b0);
    step(1, 8'h5A, 0, 3'b000, 2'd0, 2'd2, 2'd3, 3'd2, 1'b0);
    step(1, 8'h1C, 0, 3'b000, 2'd0, 2'd2, 2'd3, 3'd0, 1'b0);
    step(1, 8'h18, 0, 3'b000, 2'd0, 2'd2, 2'd3, 3'd3, 1'b0);
    step(1, 8'h13, 0, 3'b000, 2'd0, 2'd2, 2'd3, 3'd3, 1'b0);
    step(1, 8'h10, 0, 3'b000, 2'd0, 2'd0, 2'd3, 3'd0, 1'b1);

    // mode code beats simultaneous detection
    step(1, 8'h0F, 0, 3'b000, 2'd0, 2'd1, 2'd0, 3'd2, 1'b1);
    step(1, 8'h10, 1, 3'b011, 2'd0, 2'd0, 2'd3, 3'd0, 1'b1);

    // FOLLOW direction decode, CAM code while following keeps FOLLOW
    step(1, 8'h0F, 0, 3'b000, 2'd0, 2'd1, 2'd0, 3'd2, 1'b1);
    step(0, 8'h00, 1, 3'b001, 2'd0, 2'd1, 2'd1, 3'd1, 1'b1);
    step(1, 8'h0F, 1, 3'b010, 2'd0, 2'd1, 2'd1, 3'd2, 1'b1);
    step(0, 8'h00, 1, 3'b100, 2'd0, 2'd1, 2'd1, 3'd0, 1'b1);
    step(0, 8'h00, 1, 3'b011, 2'd1, 2'd1, 2'd1, 3'd4, 1'b0);

    // asynchronous reset mid-FOLLOW
    #2;
    reset = 1'b1;
    sb.push_back(mk(2'd0, 2'd3, 3'd0, 1'b1));
    #1;
    check_out();
    step(0, 8'h00, 0, 3'b000, 2'd0, 2'd0, 2'd3, 3'd0, 1'b1);
    reset = 1'b0;
    step(0, 8'h00, 0, 3'b000, 2'd0, 2'd0, 2'd3, 3'd0, 1'b1);
    step(0, 8'h00, 0, 3'b000, 2'd0, 2'd0, 2'd3, 3'd0, 1'b1);
    step(0, 8'h00, 0, 3'b000, 2'd0, 2'd0, 2'd3, 3'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
